// File: rtl/fft_bin_to_bars.sv
// fft_bin_to_bars: turns each FFT output frame into NUM_COLS log2 bar heights
// with a one-step-per-frame fall-off, readable through a registered port.
//
// Handshake: the FFT source side has no ready. Every source_* input is meaningful
// only in a cycle with source_valid high. A valid beat is either consumed (IDLE with
// sop, or ACCUM) or ignored (IDLE without sop, DRAIN, FINISH, DISCARD).
module fft_bin_to_bars #(
  parameter int SAMPLE_LEGTH   = 24,
  parameter int FFT_SIZE_WIDTH = 10,
  parameter int NUM_COLS       = 32,
  parameter int MAX_HEIGHT     = 16,
  parameter int HEIGHT_OFFSET  = 9
) (
  input  logic                           MCLK,
  input  logic                           reset,
  input  logic                           source_valid,
  input  logic                           source_sop,
  input  logic                           source_eop,
  input  logic signed [SAMPLE_LEGTH-1:0] source_real,
  input  logic signed [SAMPLE_LEGTH-1:0] source_imag,
  input  logic signed [5:0]              source_exp,
  input  logic [1:0]                     source_error,
  input  logic [4:0]                     col_rd_addr,
  output logic [4:0]                     col_height,
  output logic                           frame_done,
  output logic                           frame_err
);

  localparam int FFT_SIZE = 1 << FFT_SIZE_WIDTH;
  localparam int HALF     = FFT_SIZE / 2;
  localparam int BPC      = HALF / NUM_COLS;
  localparam int BPC_W    = $clog2(BPC);
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int MAG_W    = SAMPLE_LEGTH + 1;
  localparam logic [FFT_SIZE_WIDTH-1:0] LAST_BIN = FFT_SIZE_WIDTH'(FFT_SIZE - 1);
  localparam logic signed [7:0] OFFSET_S = 8'(HEIGHT_OFFSET);
  localparam logic signed [7:0] MAX_S    = 8'(MAX_HEIGHT);

  // FSM state is kept in r_state so checkers can bind to it directly.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    DRAIN   = 3'd2,
    FINISH  = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      w_err_pulse;
  logic                      w_done_pulse;

  logic [FFT_SIZE_WIDTH-1:0] r_bin_cnt;
  logic                      r_bad;
  logic signed [5:0]         r_exp;
  logic                      r_drain;
  logic [COL_W-1:0]          r_col;
  logic [4:0]                r_stored [NUM_COLS];

  logic                      r_s1_valid;
  logic [MAG_W-1:0]          r_s1_mag;
  logic [FFT_SIZE_WIDTH-1:0] r_s1_bin;
  logic [MAG_W-1:0]          r_peak;
  logic [MAG_W-1:0]          r_peak_mem [NUM_COLS];

  logic                      w_accept;
  logic [FFT_SIZE_WIDTH-1:0] w_bin;
  logic                      w_bad_next;
  logic [SAMPLE_LEGTH-1:0]   w_abs_re;
  logic [SAMPLE_LEGTH-1:0]   w_abs_im;
  logic [MAG_W-1:0]          w_mag;
  logic                      w_s1_in_half;
  logic [COL_W-1:0]          w_s1_col;
  logic [MAG_W-1:0]          w_peak_base;
  logic [MAG_W-1:0]          w_peak_next;
  logic                      w_s2_write;
  logic [MAG_W-1:0]          w_fin_peak;
  logic [7:0]                w_len;
  logic signed [7:0]         w_e;
  logic signed [7:0]         w_h_raw;
  logic [4:0]                w_h;
  logic [4:0]                w_old_h;
  logic [4:0]                w_new_h;

  // Number of significant bits of a magnitude (0 for zero).
  function automatic logic [7:0] bit_len(input logic [MAG_W-1:0] v);
    logic [7:0] len;
    len = 8'd0;
    for (int i = 0; i < MAG_W; i++) begin
      if (v[i]) len = 8'(i + 1);
    end
    return len;
  endfunction

  assign w_accept   = source_valid && ((r_state == ACCUM) || (r_state == IDLE && source_sop));
  assign w_bin      = source_sop ? '0 : r_bin_cnt;
  assign w_bad_next = (source_sop ? 1'b0 : r_bad) | (|source_error);

  // Stage-1 magnitude: max + min/2; abs of the most negative value fits unsigned.
  always_comb begin
    w_abs_re = source_real[SAMPLE_LEGTH-1] ? (~source_real + 1'b1) : source_real;
    w_abs_im = source_imag[SAMPLE_LEGTH-1] ? (~source_imag + 1'b1) : source_imag;
    if (w_abs_re >= w_abs_im) w_mag = {1'b0, w_abs_re} + {2'b00, w_abs_im[SAMPLE_LEGTH-1:1]};
    else                      w_mag = {1'b0, w_abs_im} + {2'b00, w_abs_re[SAMPLE_LEGTH-1:1]};
  end

  // Stage-1 register: magnitude and bin index of each consumed beat.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_bin   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_mag   <= w_mag;
      r_s1_bin   <= w_bin;
    end
  end

  // Stage-2 peak: restart at each column's first bin, DC bin never contributes.
  always_comb begin
    w_s1_in_half = (r_s1_bin < FFT_SIZE_WIDTH'(HALF));
    w_s1_col     = r_s1_bin[BPC_W +: COL_W];
    w_peak_base  = (r_s1_bin[BPC_W-1:0] == '0) ? '0 : r_peak;
    if (r_s1_bin == '0)               w_peak_next = '0;
    else if (r_s1_mag > w_peak_base)  w_peak_next = r_s1_mag;
    else                              w_peak_next = w_peak_base;
    w_s2_write = r_s1_valid && w_s1_in_half && (r_s1_bin[BPC_W-1:0] == '1);
  end

  // Stage-2 register: running peak of the current column.
  always_ff @(posedge MCLK) begin
    if (reset) r_peak <= '0;
    else if (r_s1_valid && w_s1_in_half) r_peak <= w_peak_next;
  end

  // Per-column peak store, written at each column's last bin.
  always_ff @(posedge MCLK) begin
    if (w_s2_write) r_peak_mem[w_s1_col] <= w_peak_next;
  end

  // FSM state register.
  always_ff @(posedge MCLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state and frame_done/frame_err pulse requests.
  always_comb begin
    w_state_next = r_state;
    w_err_pulse  = 1'b0;
    w_done_pulse = 1'b0;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) begin
          if (r_state == ACCUM && source_sop) w_err_pulse = 1'b1;
          if (source_eop) begin
            if (w_bin == LAST_BIN) begin
              w_state_next = w_bad_next ? DISCARD : DRAIN;
            end else begin
              w_state_next = IDLE;
              w_err_pulse  = 1'b1;
            end
          end else begin
            w_state_next = ACCUM;
          end
        end
      end
      DRAIN:   if (r_drain) w_state_next = FINISH;
      FINISH: begin
        if (r_col == COL_W'(NUM_COLS - 1)) begin
          w_state_next = IDLE;
          w_done_pulse = 1'b1;
        end
      end
      DISCARD: begin
        w_err_pulse  = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Height of the column being committed: log2 length, exponent, offset, clamp, fall-off.
  always_comb begin
    w_fin_peak = r_peak_mem[r_col];
    w_len      = bit_len(w_fin_peak);
    w_e        = $signed(w_len) - $signed({{2{r_exp[5]}}, r_exp});
    w_h_raw    = w_e - OFFSET_S;
    if (w_h_raw < 8'sd0)     w_h = 5'd0;
    else if (w_h_raw > MAX_S) w_h = 5'(MAX_HEIGHT);
    else                     w_h = w_h_raw[4:0];
    w_old_h = r_stored[r_col];
    if (w_h >= w_old_h)      w_new_h = w_h;
    else if (w_old_h == '0)  w_new_h = 5'd0;
    else                     w_new_h = w_old_h - 5'd1;
  end

  // Frame bookkeeping, drain/column counters, stored heights, read port and pulses.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_bin_cnt  <= '0;
      r_bad      <= 1'b0;
      r_exp      <= '0;
      r_drain    <= 1'b0;
      r_col      <= '0;
      col_height <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) r_stored[i] <= '0;
    end else begin
      if (w_accept) begin
        r_bin_cnt <= w_bin + FFT_SIZE_WIDTH'(1);
        r_bad     <= w_bad_next;
        if (source_sop) r_exp <= source_exp;
      end
      r_drain <= (r_state == DRAIN) ? ~r_drain : 1'b0;
      r_col   <= (r_state == FINISH) ? r_col + COL_W'(1) : '0;
      if (r_state == FINISH) r_stored[r_col] <= w_new_h;
      col_height <= r_stored[col_rd_addr];
      frame_done <= w_done_pulse;
      frame_err  <= w_err_pulse;
    end
  end

endmodule

// File: tb/tb_fft_bin_to_bars.sv
// Bench for fft_bin_to_bars: random-gap frame driver, frame-level reference model
// of bar heights, expected-queue scoreboard on the read port, pulse counters.
module tb_fft_bin_to_bars;

  localparam int FFT  = 1024;
  localparam int COLS = 32;

  logic        MCLK = 1'b0;
  logic        reset = 1'b1;
  logic        source_valid = 1'b0;
  logic        source_sop = 1'b0;
  logic        source_eop = 1'b0;
  logic [23:0] source_real = '0;
  logic [23:0] source_imag = '0;
  logic [5:0]  source_exp = '0;
  logic [1:0]  source_error = '0;
  logic [4:0]  col_rd_addr = '0;
  logic [4:0]  col_height;
  logic        frame_done;
  logic        frame_err;

  int          g_re  [FFT];
  int          g_im  [FFT];
  logic [1:0]  g_err [FFT];
  int          exp_h [COLS];
  logic [4:0]  exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;

  fft_bin_to_bars dut (
    .MCLK         (MCLK),
    .reset        (reset),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .source_exp   (source_exp),
    .source_error (source_error),
    .col_rd_addr  (col_rd_addr),
    .col_height   (col_height),
    .frame_done   (frame_done),
    .frame_err    (frame_err)
  );

  // Clock and pulse counters (sampled on the falling edge)
  always #10 MCLK = ~MCLK;

  always @(negedge MCLK) begin
    if (!reset && frame_done) n_done++;
    if (!reset && frame_err)  n_err++;
  end

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Driver tasks
  task automatic clear_frame();
    for (int i = 0; i < FFT; i++) begin
      g_re[i] = 0; g_im[i] = 0; g_err[i] = 2'b00;
    end
  endtask

  task automatic idle_junk();
    source_valid = 1'b0;
    source_sop   = 1'($urandom_range(0, 1));
    source_eop   = 1'($urandom_range(0, 1));
    source_real  = 24'($urandom);
    source_imag  = 24'($urandom);
    source_exp   = 6'($urandom);
    source_error = 2'($urandom);
  endtask

  task automatic drive_beats(input int n, input int exp_v, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge MCLK);
        idle_junk();
      end
      @(negedge MCLK);
      source_valid = 1'b1;
      source_sop   = (i == 0);
      source_eop   = with_eop && (i == n - 1);
      source_real  = 24'(g_re[i]);
      source_imag  = 24'(g_im[i]);
      source_exp   = (i == 0) ? 6'(exp_v) : 6'($urandom);
      source_error = g_err[i];
    end
    @(negedge MCLK);
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
    source_error = 2'b00;
  endtask

  task automatic settle(input string tag, input int d0, input int e0,
                        input int want_done, input int want_err);
    repeat (60) @(negedge MCLK);
    chk({tag, "_done_cnt"}, n_done - d0, want_done);
    chk({tag, "_err_cnt"},  n_err - e0,  want_err);
  endtask

  // Reference model: whole-frame bar heights from the arithmetic rules
  task automatic model_frame(input int exp_v);
    int peak, a, b, mag, len, h;
    for (int i = 0; i < FFT; i++) if (g_err[i] != 2'b00) return;
    for (int c = 0; c < COLS; c++) begin
      peak = 0;
      for (int k = 16 * c; k < 16 * c + 16; k++) begin
        if (k == 0) continue;
        a = (g_re[k] < 0) ? -g_re[k] : g_re[k];
        b = (g_im[k] < 0) ? -g_im[k] : g_im[k];
        mag = (a > b) ? a + b / 2 : b + a / 2;
        if (mag > peak) peak = mag;
      end
      len = 0;
      while ((peak >> len) != 0) len++;
      h = len - exp_v - 9;
      if (h < 0) h = 0;
      if (h > 16) h = 16;
      exp_h[c] = (h >= exp_h[c]) ? h : ((exp_h[c] > 0) ? exp_h[c] - 1 : 0);
    end
  endtask

  // Scoreboard: queue the model heights, then read back every column
  task automatic read_all(input string tag);
    logic [4:0] want;
    for (int c = 0; c < COLS; c++) exp_q.push_back(5'(exp_h[c]));
    for (int c = 0; c < COLS; c++) begin
      @(negedge MCLK);
      col_rd_addr = 5'(c);
      @(negedge MCLK);
      want = exp_q.pop_front();
      chk($sformatf("%s_col%0d", tag, c), int'(col_height), int'(want));
    end
  endtask

  function automatic int rnd_val();
    int k, v;
    k = $urandom_range(0, 23);
    v = int'($urandom & ((32'd1 << k) - 32'd1));
    if ($urandom_range(0, 1) == 1) v = -v;
    if ($urandom_range(0, 200) == 0) v = -(1 << 23);
    return v;
  endfunction

  task automatic tone_frame(input int bin);
    clear_frame();
    g_re[0]   = 24'h7FFFFF;
    g_re[bin] = 24'h100000;
  endtask

  initial begin
    int d0, e0, ev;
    for (int c = 0; c < COLS; c++) exp_h[c] = 0;

    // Reset
    repeat (5) @(negedge MCLK);
    reset = 1'b0;
    @(negedge MCLK);
    chk("rst_col_height", int'(col_height), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_err",  int'(frame_err), 0);
    read_all("rst");
    chk("rst_no_pulses", n_done + n_err, 0);

    // Single tone, then repeat and decay over zero frames
    for (int f = 0; f < 5; f++) begin
      if (f < 2) tone_frame(40);
      else       clear_frame();
      d0 = n_done; e0 = n_err;
      drive_beats(FFT, 0, 1'b1);
      model_frame(0);
      settle($sformatf("tone%0d", f), d0, e0, 1, 0);
      read_all($sformatf("tone%0d", f));
    end
    chk("decay_col2_model", exp_h[2], 9);

    // Saturation: most negative re/im in bin 1 with exp = -6
    clear_frame();
    g_re[1] = -(1 << 23);
    g_im[1] = -(1 << 23);
    d0 = n_done; e0 = n_err;
    drive_beats(FFT, -6, 1'b1);
    model_frame(-6);
    settle("sat", d0, e0, 1, 0);
    read_all("sat");

    // Bad frame: error code on bin 500 discards the frame
    tone_frame(40);
    g_err[500] = 2'b01;
    d0 = n_done; e0 = n_err;
    drive_beats(FFT, 0, 1'b1);
    model_frame(0);
    settle("errfrm", d0, e0, 0, 1);
    read_all("errfrm");

    // Restart: frame A cut by a new sop at bin 300, then full frame B
    clear_frame();
    for (int i = 1; i < 301; i++) begin g_re[i] = rnd_val(); g_im[i] = rnd_val(); end
    d0 = n_done; e0 = n_err;
    drive_beats(301, -4, 1'b0);
    tone_frame(100);
    drive_beats(FFT, 0, 1'b1);
    model_frame(0);
    settle("restart", d0, e0, 1, 1);
    read_all("restart");

    // Short frame: eop at bin 699
    tone_frame(200);
    d0 = n_done; e0 = n_err;
    drive_beats(700, 0, 1'b1);
    settle("short", d0, e0, 0, 1);
    read_all("short");

    // Random frames with random block exponents
    for (int f = 0; f < 4; f++) begin
      clear_frame();
      for (int i = 0; i < FFT; i++) begin g_re[i] = rnd_val(); g_im[i] = rnd_val(); end
      ev = $urandom_range(0, 12) - 6;
      d0 = n_done; e0 = n_err;
      drive_beats(FFT, ev, 1'b1);
      model_frame(ev);
      settle($sformatf("rnd%0d", f), d0, e0, 1, 0);
      read_all($sformatf("rnd%0d", f));
    end

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bin_to_bars.md
Name: fft_bin_to_bars

Overview:
- Downstream consumer of the FFT core's source (Avalon-ST) interface. Converts each 1024-bin FFT output frame into 32 bar heights (0..16) for the LED matrix driver.
- Per bin: computes an approximate magnitude, takes a running peak per column, converts the peak to a log2 bar height using the frame's block exponent, and applies a one-step-per-frame fall-off.
- The matrix driver reads heights through a registered read port.

Parameters:
- SAMPLE_LEGTH, 24, width of source_real/source_imag (signed).
- FFT_SIZE_WIDTH, 10, log2 of FFT size; FFT_SIZE = 1<<FFT_SIZE_WIDTH.
- NUM_COLS, 32, number of bar columns; bins per column = (FFT_SIZE/2)/NUM_COLS = 16.
- MAX_HEIGHT, 16, bar height ceiling.
- HEIGHT_OFFSET, 9, log2 noise floor subtracted before clamping.

Ports:
- MCLK  input  1  system clock, 50 MHz; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- source_valid  input  1  FFT output beat valid.
- source_sop  input  1  first bin of frame, qualified by source_valid.
- source_eop  input  1  last bin of frame, qualified by source_valid.
- source_real  input  SAMPLE_LEGTH  signed real part.
- source_imag  input  SAMPLE_LEGTH  signed imaginary part.
- source_exp  input  6  signed block exponent; true magnitude = mag * 2^(-exp).
- source_error  input  2  FFT error code; nonzero marks the frame bad.
- col_rd_addr  input  5  column index to read.
- col_height  output  5  height of column col_rd_addr; 1-cycle read latency.
- frame_done  output  1  1-cycle pulse when a frame's heights are fully committed.
- frame_err  output  1  1-cycle pulse when a frame is discarded.

Behaviour:
- Reset: all 32 stored heights = 0, col_height = 0, frame_done = 0, frame_err = 0, FSM = IDLE, all counters = 0. Reset mid-frame abandons the frame without any pulse.
- Magnitude (stage 1, registered): a = |re|, b = |im| (|-2^23| = 2^23, no saturation). mag = max(a,b) + (min(a,b)>>1), 25 bits unsigned, no overflow possible.
- Bin counter: 0 on the sop beat, +1 per valid beat.
  - Bin 0 (DC) and bins >= FFT_SIZE/2 are excluded from all peaks.
  - Column = bin>>4, so column 0 covers bins 1..15.
- Running peak (stage 2): reset to 0 at each column start; peak = max(peak, mag). At the column's last bin (bin[3:0]==15), write peak to peak_mem[col].
- source_exp: latched on the sop beat; later values are ignored for that frame.
- FSM states:
  - IDLE: valid && sop -> ACCUM (bin 0). Valid beats without sop are ignored.
  - ACCUM: valid && sop -> restart the frame in ACCUM, pulse frame_err, discard the partial frame. Valid && eop with bin == FFT_SIZE-1 -> FINISH (or DISCARD if the bad flag is set). Eop at any other count -> IDLE, frame_err pulse. A nonzero source_error on any beat sets bad.
  - FINISH: one column per cycle, c = 0..31 (32 cycles).
    - L = MSB index of peak_mem[c] + 1, or 0 if the peak is 0.
    - e = L - exp_latched (signed, 8 bits).
    - h = clamp(e - HEIGHT_OFFSET, 0, MAX_HEIGHT).
    - stored[c] = (h >= stored[c]) ? h : stored[c] - 1, floor 0.
    - After c = 31: frame_done pulses the next cycle, then -> IDLE.
  - DISCARD: frame_err pulses for 1 cycle, stored heights unchanged -> IDLE.
- Frames arriving while in FINISH or DISCARD: the sop is ignored and the whole frame is dropped silently (IDLE ignores beats until the next sop).
- Pipeline: 2 register stages between a beat and its peak_mem write. The eop -> FINISH transition waits for the pipeline to drain (2 cycles).
- Read port: col_height <= stored[col_rd_addr] every cycle.
  - During FINISH the reader may see a mix of old and new columns; this tear is permitted.
  - A read of the column being written in the same cycle returns the old value.

Test Plan:
- Reset, then read all 32 addresses -> col_height = 0 each; frame_done and frame_err stay 0.
- Single tone, exp = 0: bin 0 re = 0x7FFFFF, bin 40 re = 0x100000, all others 0 -> column 2 = 12 (L = 21, 21-9); all other columns = 0 (DC ignored); exactly one frame_done pulse.
- Decay: repeat the tone frame, then 3 all-zero frames -> column 2 reads 12, 11, 10, 9 after successive frame_done pulses.
- Saturation: bin 1 re = im = -2^23, exp = -6 -> mag = 0xC00000, L = 24, e = 30 -> column 0 = 16 (clamped).
- Error: tone frame with source_error = 2'b01 on bin 500 -> frame_err pulses once, no frame_done, heights unchanged.
- Restart: second sop at bin 300 of frame A, then a full 1024-bin frame B with the tone at bin 100 -> one frame_err pulse; column 6 = 12; no contribution from frame A.
